// File: rtl/hazard_mc.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, load-use and multiply stalls, flushes.
// Optional perf counters (LdStallCnt, MulStallCnt) are built when HAZ_PERF_CNT_EN is defined.
module hazard_mc #(
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] RA_E,
    input  logic [2*REG_AW-1:0]       RA_D,
    input  logic [REG_AW-1:0]         WA_E,
    input  logic [REG_AW-1:0]         WA_M,
    input  logic [REG_AW-1:0]         WA_W,
    input  logic                      MemtoRegE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MulStartE,
    input  logic                      BranchTakenD,
    input  logic                      PCWrPendingF,
    input  logic                      PCSrcW,
    output logic [2*NUM_SRC-1:0]      Forward,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      MulBusy,
    output logic                      MulDoneE
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]          LdStallCnt,
    output logic [CNT_W-1:0]          MulStallCnt
`endif
);

    localparam int unsigned CntBits = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam bit MulMulti = (MUL_LAT > 1);
    localparam logic [CntBits-1:0] CntLoad = CntBits'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
    localparam logic [REG_AW-1:0] PcAddr = '1;

    typedef enum logic {StIdle, StBusy} mul_state_t;

    mul_state_t         r_state, w_state_d;
    logic [CntBits-1:0] r_cnt, w_cnt_d;
    logic               w_ld_stall, w_mul_stall, w_mul_done;

    // M stage result is newer than W, so it wins; the PC is never forwarded
    for (genvar gi = 0; gi < int'(NUM_SRC); gi++) begin : g_fwd
        logic [REG_AW-1:0] w_ra;
        assign w_ra = RA_E[gi*REG_AW +: REG_AW];
        assign Forward[2*gi +: 2] =
            (w_ra == PcAddr)                 ? 2'b00 :
            (RegWriteM && (WA_M == w_ra))    ? 2'b10 :
            (RegWriteW && (WA_W == w_ra))    ? 2'b01 : 2'b00;
    end

    assign w_ld_stall = MemtoRegE &&
                        ((RA_D[REG_AW-1:0] == WA_E) || (RA_D[2*REG_AW-1:REG_AW] == WA_E));

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_mul_stall = 1'b0;
        w_mul_done  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MulStartE) begin
                    if (MulMulti) begin
                        w_mul_stall = 1'b1;
                        w_state_d   = StBusy;
                        w_cnt_d     = CntLoad;
                    end else begin
                        w_mul_done = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (r_cnt != '0) begin
                    w_mul_stall = 1'b1;
                    w_cnt_d     = r_cnt - 1'b1;
                end else begin
                    w_mul_done = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        // A PC write from W kills any multiply in flight
        if (PCSrcW) begin
            w_state_d   = StIdle;
            w_cnt_d     = '0;
            w_mul_stall = 1'b0;
            w_mul_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign MulBusy  = (r_state == StBusy);
    assign MulDoneE = w_mul_done;
    assign StallF   = !PCSrcW && (w_ld_stall || w_mul_stall || PCWrPendingF);
    assign StallD   = !PCSrcW && (w_ld_stall || w_mul_stall);
    assign StallE   = !PCSrcW && w_mul_stall;
    assign FlushD   = PCSrcW || PCWrPendingF || (BranchTakenD && !w_mul_stall);
    assign FlushE   = PCSrcW || (!w_mul_stall && (w_ld_stall || BranchTakenD));
    assign FlushM   = !PCSrcW && w_mul_stall;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_ld_cnt, r_mul_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_cnt  <= '0;
            r_mul_cnt <= '0;
        end else begin
            if (w_ld_stall && (r_ld_cnt != '1)) r_ld_cnt <= r_ld_cnt + 1'b1;
            if (w_mul_stall && (r_mul_cnt != '1)) r_mul_cnt <= r_mul_cnt + 1'b1;
        end
    end

    assign LdStallCnt  = r_ld_cnt;
    assign MulStallCnt = r_mul_cnt;
`endif

endmodule

// File: tb/tb_hazard_mc.sv
// Bench for hazard_mc: directed cases followed by random stimulus against a cycle-position model.
module tb_hazard_mc;
    localparam int NS = 3;
    localparam int AW = 4;
    localparam int ML = 3;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [NS*AW-1:0] RA_E;
    logic [2*AW-1:0]  RA_D;
    logic [AW-1:0]    WA_E, WA_M, WA_W;
    logic MemtoRegE, RegWriteM, RegWriteW, MulStartE, BranchTakenD, PCWrPendingF, PCSrcW;
    logic [2*NS-1:0]  Forward;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE;
    logic [CW-1:0]    LdStallCnt, MulStallCnt;

    int total = 0;
    int bad = 0;
    int m_pos = 0;     // cycle index of the multiply carried into this cycle; 0 = none
    int m_ld_cnt = 0;
    int m_mul_cnt = 0;
    int e_idx;
    logic e_ms, e_ld;

    hazard_mc #(.NUM_SRC(NS), .REG_AW(AW), .MUL_LAT(ML), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .RA_E(RA_E), .RA_D(RA_D),
        .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MulStartE(MulStartE), .BranchTakenD(BranchTakenD),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
        .Forward(Forward), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MulBusy(MulBusy), .MulDoneE(MulDoneE)
`ifdef HAZ_PERF_CNT_EN
        , .LdStallCnt(LdStallCnt), .MulStallCnt(MulStallCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] raddr();
        return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
    endfunction

    task automatic compare_all(input string tag);
        logic [2*NS-1:0] ef;
        logic [3:0] a;
        logic md, sf, sd, fd, fe;
        if (reset) begin
            m_pos = 0;
            m_ld_cnt = 0;
            m_mul_cnt = 0;
        end
        e_idx = (m_pos > 0) ? m_pos : (MulStartE ? 0 : -1);
        e_ms  = !PCSrcW && (e_idx >= 0) && (e_idx < ML - 1);
        md    = !PCSrcW && (e_idx == ML - 1);
        e_ld  = MemtoRegE && ((RA_D[3:0] == WA_E) || (RA_D[7:4] == WA_E));
        sf = !PCSrcW && (e_ld || e_ms || PCWrPendingF);
        sd = !PCSrcW && (e_ld || e_ms);
        fd = PCSrcW || PCWrPendingF || (BranchTakenD && !e_ms);
        fe = PCSrcW || (!e_ms && (e_ld || BranchTakenD));
        for (int i = 0; i < NS; i++) begin
            a = RA_E[i*AW +: AW];
            if (a == 4'hF) ef[2*i +: 2] = 2'b00;
            else if (RegWriteM && WA_M == a) ef[2*i +: 2] = 2'b10;
            else if (RegWriteW && WA_W == a) ef[2*i +: 2] = 2'b01;
            else ef[2*i +: 2] = 2'b00;
        end
        check({tag, ".fwd"}, 32'(Forward), 32'(ef));
        check({tag, ".ctl"}, 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE}),
              32'({sf, sd, e_ms, fd, fe, e_ms, (m_pos > 0), md}));
`ifdef HAZ_PERF_CNT_EN
        check({tag, ".cnt"}, 32'({LdStallCnt, MulStallCnt}), 32'((m_ld_cnt << CW) | m_mul_cnt));
`endif
    endtask

    // Inputs are driven 1 time unit after a rising edge; checks land at +3.
    task automatic step(input string tag);
        #2;
        compare_all(tag);
        @(posedge clk);
        if (reset) begin
            m_pos = 0;
            m_ld_cnt = 0;
            m_mul_cnt = 0;
        end else begin
            m_pos = e_ms ? e_idx + 1 : 0;
            if (e_ld && m_ld_cnt < CMAX) m_ld_cnt++;
            if (e_ms && m_mul_cnt < CMAX) m_mul_cnt++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; RA_E = '0; RA_D = '0; WA_E = '0; WA_M = '0; WA_W = '0;
        MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0; MulStartE = 0;
        BranchTakenD = 0; PCWrPendingF = 0; PCSrcW = 0;
        #1;
        check("rst_busy", 32'(MulBusy), 32'd0);
        step("rst");
        reset = 1'b0;
        step("idle");

        // forwarding priority and PC exclusion
        RA_E = 12'h003; WA_M = 4'd3; RegWriteM = 1; WA_W = 4'd3; RegWriteW = 1;
        #1 check("fwd_m", 32'(Forward[1:0]), 32'd2);
        RegWriteM = 0;
        #1 check("fwd_w", 32'(Forward[1:0]), 32'd1);
        RA_E = 12'h00F; WA_M = 4'hF; WA_W = 4'hF; RegWriteM = 1;
        #1 check("fwd_pc", 32'(Forward[1:0]), 32'd0);
        step("fwd");
        RA_E = '0; RegWriteM = 0; RegWriteW = 0; WA_M = 0; WA_W = 0;

        // load-use
        MemtoRegE = 1; WA_E = 4'd5; RA_D = {4'd5, 4'd0};
        #1 check("lduse", 32'({StallF, StallD, FlushE, Forward[1:0]}), 32'b11100);
        step("lduse");
        MemtoRegE = 0;
        #1 check("lduse_rel", 32'({StallF, StallD, FlushE}), 32'd0);
        step("lduse_rel");

        // single multiply
        MulStartE = 1;
        #1 check("mul_c0", 32'({StallE, FlushM, MulBusy, MulDoneE}), 32'b1100);
        step("mul_c0");
        #1 check("mul_c1", 32'({StallE, FlushM, MulBusy, MulDoneE}), 32'b1110);
        step("mul_c1");
        #1 check("mul_c2", 32'({StallE, FlushM, MulBusy, MulDoneE}), 32'b0011);
        step("mul_c2");

        // back-to-back multiplies
        for (int c = 0; c < 6; c++) begin
            #1 check("b2b_done", 32'(MulDoneE), 32'((c == 2) || (c == 5)));
            step("b2b");
        end
        MulStartE = 0;
        #1 check("b2b_idle", 32'(MulBusy), 32'd0);
        step("b2b_idle");

        // abort by PC write in BUSY
        MulStartE = 1;
        step("abort_c0");
        PCSrcW = 1;
        #1 check("abort", 32'({StallE, FlushE, FlushD}), 32'b011);
        step("abort");
        PCSrcW = 0; MulStartE = 0;
        #1 check("abort_idle", 32'(MulBusy), 32'd0);
        step("abort_idle");

        // reset mid-multiply
        MulStartE = 1;
        step("rmul_c0");
        #1 check("rmul_busy", 32'(MulBusy), 32'd1);
        reset = 1;
        #1 check("rmul_rst", 32'({MulBusy, MulDoneE}), 32'd0);
        step("rmul_rst");
        reset = 0; MulStartE = 0;
        step("rmul_after");

`ifdef HAZ_PERF_CNT_EN
        reset = 1;
        step("perf_rst");
        reset = 0; MulStartE = 1;
        for (int c = 0; c < 7; c++) step("perf");
        MulStartE = 0;
        #1 check("perf_sat", 32'(MulStallCnt), 32'd3);
        step("perf_end");
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NS; i++) RA_E[i*AW +: AW] = raddr();
            RA_D = {raddr(), raddr()};
            WA_E = raddr(); WA_M = raddr(); WA_W = raddr();
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            RegWriteM    = $urandom_range(0, 1) == 1;
            RegWriteW    = $urandom_range(0, 1) == 1;
            MulStartE    = ($urandom_range(0, 2) != 0);
            BranchTakenD = ($urandom_range(0, 5) == 0);
            PCWrPendingF = ($urandom_range(0, 7) == 0);
            PCSrcW       = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
